metronome_arm_sequencer: RTL and testbench

// Sequences the metronome-arm position ROM (sync read, 1-cycle latency) so the arm swings in time with a BPM setting.
// A phase accumulator produces step ticks. Positions run ping-pong through 0..NUM_POS-1, and one swing equals one beat.

---
 rtl/metronome_arm_sequencer_if.sv | 31 +++
 rtl/metronome_arm_sequencer.sv | 153 +++++++++++++++
 tb/tb_metronome_arm_sequencer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/metronome_arm_sequencer_if.sv
// ROM read port and erase/draw word stream between the arm sequencer and its ROM/frame drawer.
// No logic or latency of its own; out_valid/out_ready carry the backpressure.
interface metronome_arm_sequencer_if #(
    parameter int DATA_WIDTH = 19,
    parameter int ADDR_WIDTH = 7
);
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_q;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_erase;

    modport master (
        output rom_addr,
        input  rom_q,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_erase
    );

    modport slave (
        input  rom_addr,
        output rom_q,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_erase
    );
endinterface

// File: rtl/metronome_arm_sequencer.sv
// Steps the metronome arm ping-pong through the position ROM at the BPM rate; tick to erase word = 3 clk.
// out_valid holds its word until out_ready; one tick may queue while busy, further ones are dropped (overrun).
module metronome_arm_sequencer #(
    parameter int DATA_WIDTH = 19,
    parameter int ADDR_WIDTH = 7,
    parameter int NUM_POS    = 32,
    parameter int CLK_HZ     = 50_000_000,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  run,
    input  logic [7:0]            bpm,
    metronome_arm_sequencer_if.master bus,
    output logic                  beat,
    output logic [ADDR_WIDTH-1:0] pos,
    output logic                  busy,
    output logic                  overrun
);

    localparam longint LIMIT_L = longint'(CLK_HZ) * longint'(60);
    localparam logic [ACC_WIDTH-1:0]  LIMIT    = ACC_WIDTH'(LIMIT_L);
    localparam logic [ACC_WIDTH-1:0]  STEP_MUL = ACC_WIDTH'(NUM_POS - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_POS = ADDR_WIDTH'(NUM_POS - 1);

    typedef enum logic [2:0] {
        INIT, IDLE, RD_OLD, CAP_OLD, SEND_OLD, RD_NEW, CAP_NEW, SEND_NEW
    } state_t;

    state_t                state, state_nxt;
    logic [ACC_WIDTH-1:0]  acc, sum;
    logic                  tick;
    logic                  pending;
    logic                  dir_down;
    logic                  first_draw;
    logic [ADDR_WIDTH-1:0] nxt;
    logic                  start;
    logic                  accept;

    // Each beat must advance NUM_POS-1 steps, so the phase increment is bpm*(NUM_POS-1) against clk*60.
    always_comb begin
        sum  = acc + ACC_WIDTH'(bpm) * STEP_MUL;
        tick = run && (sum >= LIMIT);
        nxt  = dir_down ? (pos - ADDR_WIDTH'(1)) : (pos + ADDR_WIDTH'(1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        accept    = bus.out_valid && bus.out_ready;
        case (state)
            INIT:     state_nxt = CAP_NEW;
            IDLE: begin
                if (tick || (pending && run)) begin
                    state_nxt = RD_OLD;
                    start     = 1'b1;
                end
            end
            RD_OLD:   state_nxt = CAP_OLD;
            CAP_OLD:  state_nxt = SEND_OLD;
            SEND_OLD: if (accept) state_nxt = RD_NEW;
            RD_NEW:   state_nxt = CAP_NEW;
            CAP_NEW:  state_nxt = SEND_NEW;
            SEND_NEW: if (accept) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc           <= '0;
            pending       <= 1'b0;
            overrun       <= 1'b0;
            dir_down      <= 1'b0;
            first_draw    <= 1'b1;
            pos           <= '0;
            beat          <= 1'b0;
            busy          <= 1'b0;
            bus.rom_addr  <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_erase <= 1'b0;
        end else begin
            if (run) begin
                acc <= tick ? (sum - LIMIT) : sum;
            end else begin
                acc <= '0;
            end

            // IDLE always consumes whatever is queued, so pending only builds up while busy.
            if (!run || (state == IDLE)) begin
                pending <= 1'b0;
            end else if (tick) begin
                if (pending) begin
                    overrun <= 1'b1;
                end else begin
                    pending <= 1'b1;
                end
            end

            beat <= 1'b0;
            busy <= (state_nxt != IDLE);

            case (state)
                INIT: bus.rom_addr <= '0;
                IDLE: if (start) bus.rom_addr <= pos;
                CAP_OLD: begin
                    bus.out_data  <= bus.rom_q;
                    bus.out_erase <= 1'b1;
                    bus.out_valid <= 1'b1;
                end
                SEND_OLD: begin
                    if (accept) begin
                        bus.out_valid <= 1'b0;
                        bus.rom_addr  <= nxt;
                    end
                end
                CAP_NEW: begin
                    bus.out_data  <= bus.rom_q;
                    bus.out_erase <= 1'b0;
                    bus.out_valid <= 1'b1;
                end
                SEND_NEW: begin
                    if (accept) begin
                        bus.out_valid <= 1'b0;
                        // The post-reset draw only paints position 0; it is not a step.
                        if (first_draw) begin
                            first_draw <= 1'b0;
                        end else begin
                            pos  <= nxt;
                            beat <= (nxt == '0) || (nxt == LAST_POS);
                            if (nxt == LAST_POS) begin
                                dir_down <= 1'b1;
                            end else if (nxt == '0) begin
                                dir_down <= 1'b0;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_metronome_arm_sequencer.sv
// Bench for metronome_arm_sequencer with a 5-position swing at CLK_HZ=1000 and a ROM holding addr*3.
module tb_metronome_arm_sequencer;

    localparam int DW = 19;
    localparam int AW = 7;
    localparam int NP = 5;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          run;
    logic [7:0]    bpm;
    logic          beat;
    logic [AW-1:0] pos;
    logic          busy;
    logic          overrun;

    metronome_arm_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifc ();

    metronome_arm_sequencer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_POS(NP), .CLK_HZ(1000), .ACC_WIDTH(32)
    ) dut (
        .clk(clk), .reset_n(reset_n), .run(run), .bpm(bpm), .bus(ifc),
        .beat(beat), .pos(pos), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] rom_mem [2**AW];
    initial for (int i = 0; i < 2**AW; i++) rom_mem[i] = DW'(i * 3);
    always @(posedge clk) ifc.rom_q <= rom_mem[ifc.rom_addr];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Ping-pong position after k steps from position 0 going up.
    function automatic int ppos(input int k);
        int m;
        m = k % (2 * (NP - 1));
        return (m <= NP - 1) ? m : 2 * (NP - 1) - m;
    endfunction

    int            step_idx;
    bit            init_pend, exp_erase, beat_exp;
    bit            prev_hold, prev_valid, prev_erase;
    logic [DW-1:0] prev_data;
    int            n_acc = 0, n_draw = 0, n_beat_seen = 0;
    int            rise_q[$];
    logic [DW-1:0] logd[$];
    bit            loge[$];

    // Transaction-level scoreboard: every accepted word, committed position and beat checked each cycle.
    always @(negedge clk) begin
        if (!reset_n) begin
            step_idx = 0; init_pend = 1; exp_erase = 0; beat_exp = 0;
            prev_hold = 0; prev_valid = 0;
        end else begin
            check("pos", pos, ppos(step_idx));
            check("beat", beat, beat_exp);
            if (beat) n_beat_seen++;
            beat_exp = 0;
            if (prev_hold) begin
                check("hold_valid", ifc.out_valid, 1);
                check("hold_data", ifc.out_data, prev_data);
                check("hold_erase", ifc.out_erase, prev_erase);
            end
            if (ifc.out_valid && ifc.out_erase && !prev_valid) rise_q.push_back(cyc);
            if (ifc.out_valid && ifc.out_ready) begin
                n_acc++;
                logd.push_back(ifc.out_data);
                loge.push_back(ifc.out_erase);
                if (init_pend) begin
                    check("init_data", ifc.out_data, 0);
                    check("init_erase", ifc.out_erase, 0);
                    init_pend = 0; exp_erase = 1;
                end else if (exp_erase) begin
                    check("erase_data", ifc.out_data, 3 * ppos(step_idx));
                    check("erase_flag", ifc.out_erase, 1);
                    exp_erase = 0;
                end else begin
                    step_idx++;
                    check("draw_data", ifc.out_data, 3 * ppos(step_idx));
                    check("draw_flag", ifc.out_erase, 0);
                    exp_erase = 1;
                    n_draw++;
                    beat_exp = (ppos(step_idx) == 0) || (ppos(step_idx) == NP - 1);
                end
            end
            prev_hold  = ifc.out_valid && !ifc.out_ready;
            prev_data  = ifc.out_data;
            prev_erase = ifc.out_erase;
            prev_valid = ifc.out_valid;
        end
    end

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rom_addr"}, ifc.rom_addr, 0);
        check({tag, "_out_valid"}, ifc.out_valid, 0);
        check({tag, "_out_data"}, ifc.out_data, 0);
        check({tag, "_out_erase"}, ifc.out_erase, 0);
        check({tag, "_beat"}, beat, 0);
        check({tag, "_pos"}, pos, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_overrun"}, overrun, 0);
    endtask

    int            c0, snap;
    logic [DW-1:0] saved;
    bit            activity;

    initial begin
        reset_n = 1'b1; run = 1'b0; bpm = 8'd60; ifc.out_ready = 1'b1;
        #1 reset_n = 1'b0;
        #1 check_zero("reset");
        repeat (3) step_clk();
        reset_n = 1'b1;
        repeat (10) step_clk();
        check("init_busy_done", busy, 0);

        // T1/T2: 60 bpm over 4 steps per beat at 1 kHz -> one step every 250 clk.
        rise_q.delete();
        c0 = cyc;
        run = 1'b1;
        for (int i = 0; i < 700 && rise_q.size() < 2; i++) step_clk();
        check("t1_two_erases", rise_q.size() >= 2, 1);
        if (rise_q.size() >= 2) begin
            check("t1_first_latency", rise_q[0] - c0, 252);
            check("t1_interval", rise_q[1] - rise_q[0], 250);
        end
        for (int i = 0; i < 3000 && n_draw < 9; i++) step_clk();
        check("t2_draws", n_draw, 9);
        check("t2_pos_after_9", pos, 1);
        check("t2_beats", n_beat_seen, 2);
        check("t3_log_len", n_acc >= 5, 1);
        if (n_acc >= 5) begin
            check("t3_w0", {loge[0], logd[0]}, {1'b0, 19'd0});
            check("t3_w1", {loge[1], logd[1]}, {1'b1, 19'd0});
            check("t3_w2", {loge[2], logd[2]}, {1'b0, 19'd3});
            check("t3_w3", {loge[3], logd[3]}, {1'b1, 19'd3});
            check("t3_w4", {loge[4], logd[4]}, {1'b0, 19'd6});
        end
        run = 1'b0;
        repeat (20) step_clk();

        // T4: erase word stalled for 100 clk.
        ifc.out_ready = 1'b0;
        run = 1'b1;
        for (int i = 0; i < 400 && !ifc.out_valid; i++) step_clk();
        check("t4_valid", ifc.out_valid, 1);
        check("t4_is_erase", ifc.out_erase, 1);
        saved = ifc.out_data;
        repeat (100) step_clk();
        check("t4_still_valid", ifc.out_valid, 1);
        check("t4_data_stable", ifc.out_data, saved);
        ifc.out_ready = 1'b1;
        step_clk();
        check("t4_accepted_first", ifc.out_valid, 0);
        repeat (10) step_clk();
        run = 1'b0;
        repeat (20) step_clk();

        // T5: ticks at 59/118/177 clk while stalled -> one queued, one dropped.
        check("t5_overrun_clear", overrun, 0);
        ifc.out_ready = 1'b0;
        bpm = 8'd255;
        run = 1'b1;
        repeat (200) step_clk();
        check("t5_overrun", overrun, 1);
        check("t5_busy", busy, 1);
        snap = n_draw;
        bpm = 8'd0;
        ifc.out_ready = 1'b1;
        repeat (60) step_clk();
        check("t5_extra_steps", n_draw - snap, 2);
        check("t5_idle", busy, 0);
        check("t5_sticky", overrun, 1);

        // T6: reset while a draw word is stalled.
        bpm = 8'd255;
        ifc.out_ready = 1'b0;
        for (int i = 0; i < 200 && !ifc.out_valid; i++) step_clk();
        ifc.out_ready = 1'b1;
        step_clk();
        ifc.out_ready = 1'b0;
        for (int i = 0; i < 20 && !(ifc.out_valid && !ifc.out_erase); i++) step_clk();
        check("t6_in_send_new", ifc.out_valid && !ifc.out_erase, 1);
        #2 reset_n = 1'b0;
        #1 check_zero("t6_async");
        run = 1'b0;
        ifc.out_ready = 1'b1;
        repeat (2) step_clk();
        reset_n = 1'b1;
        for (int i = 0; i < 20 && !ifc.out_valid; i++) step_clk();
        check("t6_init_valid", ifc.out_valid, 1);
        check("t6_init_erase", ifc.out_erase, 0);
        check("t6_init_data", ifc.out_data, 0);
        repeat (10) step_clk();

        snap = n_acc;
        activity = 0;
        for (int i = 0; i < 10000; i++) begin
            step_clk();
            if (busy || ifc.out_valid) activity = 1;
        end
        check("t6_run0_quiet", activity, 0);
        run = 1'b1;
        bpm = 8'd0;
        for (int i = 0; i < 10000; i++) begin
            step_clk();
            if (busy || ifc.out_valid) activity = 1;
        end
        check("t6_bpm0_quiet", activity, 0);
        check("t6_no_words", n_acc - snap, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
